// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
//   state_t   : detector FSM states (FILL while the history is incomplete,
//               ARMED once PAT_W valid bits are held)
//   clog2     : ceiling log2, used to size the fill counter
//   PAT_W_MIN / PAT_W_MAX : supported pattern length range
package seq_det_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter used for the match count.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset (count -> 0)
//   i_inc   : add one unless already at all-ones
//   i_clr   : synchronous clear, wins over i_inc
//   o_cnt   : current count, holds at 2^W-1 without wrapping
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector.
// Scans the qualified serial stream for a runtime-programmed PAT_W-bit
// pattern (pattern[PAT_W-1] is the first bit received), with overlapping or
// non-overlapping detection, a registered one-cycle match pulse and a
// saturating match counter.
// Optional build macro: SEQDET_MASK_EN adds a per-bit don't-care mask.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   cfg_load   : latch pattern/overlap_en (and mask), flush history/count
//   pattern    : pattern to match (sampled on cfg_load only)
//   overlap_en : 1 = overlapping, 0 = non-overlapping (sampled on cfg_load)
//   mask       : (SEQDET_MASK_EN only) 0 bits are don't-care
//   in_valid   : qualifies in
//   in         : serial data bit
//   out        : match pulse, one cycle after the completing bit
//   match_cnt  : saturating match count since reset/cfg_load
//   armed      : history holds PAT_W valid bits
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap_en,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0] mask,
`endif
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int                FILL_W    = clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W out of supported range");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PAT_W-1:0]   r_hist;
    logic [PAT_W-1:0]   w_hist_nxt;
    logic [PAT_W-1:0]   r_pat;
    logic               r_ovl;
    logic               r_out;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic [PAT_W-1:0]   w_win;
    logic [PAT_W-1:0]   w_mask;
    logic               w_fill_ok;
    logic               w_match;

`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0]   r_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask <= '1;
        end else if (cfg_load) begin
            r_mask <= mask;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = '1;
`endif

    // Window as it will look once the current bit is shifted in.
    assign w_win     = {r_hist[PAT_W-2:0], in};
    // The current bit completes a full window when fill is already PAT_W-1
    // (or saturated at PAT_W).
    assign w_fill_ok = (r_fill >= FILL_LAST);
    // cfg_load discards the bit presented in the same cycle.
    assign w_match   = in_valid && !cfg_load && w_fill_ok &&
                       (((w_win ^ r_pat) & w_mask) == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_hist_nxt  = r_hist;
        if (cfg_load) begin
            w_state_nxt = FILL;
            w_fill_nxt  = '0;
            w_hist_nxt  = '0;
        end else if (in_valid) begin
            w_hist_nxt = w_win;
            if (w_match && !r_ovl) begin
                // Non-overlap: the matched bits may not be reused.
                w_fill_nxt  = '0;
                w_state_nxt = FILL;
            end else begin
                if (r_fill != FILL_FULL) begin
                    w_fill_nxt = r_fill + 1'b1;
                end
                case (r_state)
                    FILL:    if (r_fill == FILL_LAST) w_state_nxt = ARMED;
                    ARMED:   w_state_nxt = ARMED;
                    default: w_state_nxt = FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_fill  <= '0;
            r_hist  <= '0;
            r_pat   <= '0;
            r_ovl   <= 1'b1;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_hist  <= w_hist_nxt;
            r_out   <= w_match;
            if (cfg_load) begin
                r_pat <= pattern;
                r_ovl <= overlap_en;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_inc   (w_match),
        .i_clr   (cfg_load),
        .o_cnt   (match_cnt)
    );

    assign out   = r_out;
    assign armed = (r_state == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param. Two instances share stimulus:
// one with an 8-bit counter and one with a 2-bit counter for saturation.
module tb_seq_detector_param;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_W_S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             cfg_load;
    logic [PAT_W-1:0] pattern;
    logic             overlap_en;
    logic             in_valid;
    logic             in_bit;

    logic               out_a, armed_a;
    logic [CNT_W-1:0]   cnt_a;
    logic               out_b, armed_b;
    logic [CNT_W_S-1:0] cnt_b;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_load   (cfg_load),
        .pattern    (pattern),
        .overlap_en (overlap_en),
`ifdef SEQDET_MASK_EN
        .mask       ({PAT_W{1'b1}}),
`endif
        .in_valid   (in_valid),
        .in         (in_bit),
        .out        (out_a),
        .match_cnt  (cnt_a),
        .armed      (armed_a)
    );

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W_S)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_load   (cfg_load),
        .pattern    (pattern),
        .overlap_en (overlap_en),
`ifdef SEQDET_MASK_EN
        .mask       ({PAT_W{1'b1}}),
`endif
        .in_valid   (in_valid),
        .in         (in_bit),
        .out        (out_b),
        .match_cnt  (cnt_b),
        .armed      (armed_b)
    );

    logic [13:0] act;
    assign act = {out_a, armed_a, cnt_a, out_b, armed_b, cnt_b};

    int checks   = 0;
    int failures = 0;

    // Reference model: the valid bits received since the last flush
    // (reset, cfg_load, or a non-overlapping match), plus latched config.
    bit             mq[$];
    bit [PAT_W-1:0] m_pat;
    bit             m_ovl;
    int             m_matches;
    bit             e_out;

    function automatic bit window_hits();
        bit [PAT_W-1:0] w;
        w = '0;
        if (mq.size() < PAT_W) return 1'b0;
        for (int i = 0; i < PAT_W; i++) w = {w[PAT_W-2:0], mq[mq.size()-PAT_W+i]};
        return (w == m_pat);
    endfunction

    function automatic logic [13:0] exp_vec();
        bit ea;
        int ca, cb;
        ea = (mq.size() >= PAT_W);
        ca = (m_matches > 255) ? 255 : m_matches;
        cb = (m_matches > 3) ? 3 : m_matches;
        return {e_out, ea, 8'(ca), e_out, ea, 2'(cb)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pat     = '0;
        m_ovl     = 1'b1;
        m_matches = 0;
        e_out     = 1'b0;
    endtask

    // Drive one cycle at the falling edge, advance the model on the rising
    // edge, and leave time 1 unit after the edge for sampling.
    task automatic step(input bit rs, input bit cl, input logic [PAT_W-1:0] p,
                        input bit ov, input bit v, input bit b);
        bit hit;
        @(negedge clk);
        rst_n      = rs;
        cfg_load   = cl;
        pattern    = p;
        overlap_en = ov;
        in_valid   = v;
        in_bit     = b;
        @(posedge clk);
        if (!rs) begin
            model_reset();
        end else if (cl) begin
            m_pat     = p;
            m_ovl     = ov;
            mq.delete();
            m_matches = 0;
            e_out     = 1'b0;
        end else if (v) begin
            mq.push_back(b);
            if (mq.size() > PAT_W) void'(mq.pop_front());
            hit   = window_hits();
            e_out = hit;
            if (hit) begin
                m_matches++;
                if (!m_ovl) mq.delete();
            end
        end else begin
            e_out = 1'b0;
        end
        #1;
    endtask

    task automatic bit_char(input byte c);
        step(1'b1, 1'b0, 4'b0110, 1'b0, (c != "x"), (c == "1"));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (act !== 14'd0 || act !== exp_vec()) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", i, act, exp_vec());
            end
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", act, exp_vec());
        end
    endtask

    task automatic test_overlap();
        string s = "101010";
        step(1'b1, 1'b1, 4'b1010, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < s.len(); i++) begin
            bit_char(s[i]);
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL overlap bit=%0d got=%b exp=%b", i + 1, act, exp_vec());
            end
        end
        checks++;
        if (cnt_a !== 8'd2 || armed_a !== 1'b1) begin
            failures++;
            $display("FAIL overlap_total got cnt=%0d armed=%b exp cnt=2 armed=1", cnt_a, armed_a);
        end
    endtask

    task automatic test_nonoverlap();
        string s = "10101010";
        step(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < s.len(); i++) begin
            bit_char(s[i]);
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL nonoverlap bit=%0d got=%b exp=%b", i + 1, act, exp_vec());
            end
        end
        checks++;
        if (cnt_a !== 8'd2) begin
            failures++;
            $display("FAIL nonoverlap_total got cnt=%0d exp 2", cnt_a);
        end
    endtask

    task automatic test_gaps();
        string s = "10xxx10x";
        step(1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < s.len(); i++) begin
            bit_char(s[i]);
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL gaps idx=%0d got=%b exp=%b", i, act, exp_vec());
            end
        end
        checks++;
        if (cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL gaps_total got cnt=%0d exp 1", cnt_a);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bit_char("1");
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL saturation bit=%0d got=%b exp=%b", i + 1, act, exp_vec());
            end
        end
        checks++;
        if (cnt_a !== 8'd7 || cnt_b !== 2'd3) begin
            failures++;
            $display("FAIL saturation_total got cnt8=%0d cnt2=%0d exp 7 and 3", cnt_a, cnt_b);
        end
    endtask

    task automatic test_cfg_midstream();
        string pre  = "101";
        string post = "01010";
        step(1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < pre.len(); i++) bit_char(pre[i]);
        step(1'b1, 1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);
        checks++;
        if (act !== exp_vec() || cnt_a !== 8'd0 || armed_a !== 1'b0) begin
            failures++;
            $display("FAIL cfg_mid_load got=%b exp=%b", act, exp_vec());
        end
        for (int i = 0; i < post.len(); i++) begin
            bit_char(post[i]);
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL cfg_mid bit=%0d got=%b exp=%b", i, act, exp_vec());
            end
        end
        checks++;
        if (cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL cfg_mid_total got cnt=%0d exp 1", cnt_a);
        end
    endtask

    task automatic test_zero_pattern();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bit_char("0");
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL zero_pat bit=%0d got=%b exp=%b", i + 1, act, exp_vec());
            end
        end
        checks++;
        if (cnt_a !== 8'd2) begin
            failures++;
            $display("FAIL zero_pat_total got cnt=%0d exp 2", cnt_a);
        end
    endtask

    task automatic test_random();
        bit             rs, cl, ov, v, b;
        logic [PAT_W-1:0] p;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 99) >= 2);
            cl = ($urandom_range(0, 99) < 4);
            ov = $urandom_range(0, 1);
            v  = ($urandom_range(0, 99) < 80);
            b  = $urandom_range(0, 1);
            p  = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
            step(rs, cl, p, ov, v, b);
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_load   = 1'b0;
        pattern    = '0;
        overlap_en = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        model_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_saturation();
        test_cfg_midstream();
        test_zero_pattern();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector. It is the next generation of the fixed-pattern, single-input sequence FSM used in the homework blocks. It scans a qualified serial bitstream for a runtime-programmable PAT_W-bit pattern, with selectable overlapping or non-overlapping detection. It emits a one-cycle match pulse and keeps a saturating match count. It sits between a serial source and a control/status consumer.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
CNT_W, 8, match counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
cfg_load  input  1  latch pattern/overlap_en, flush history
pattern  input  PAT_W  pattern to match; pattern[PAT_W-1] is the first bit received
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
in_valid  input  1  qualifies in for this cycle
in  input  1  serial data bit
out  output  1  match pulse, one cycle wide
match_cnt  output  CNT_W  saturating count of matches since reset/cfg_load
armed  output  1  history holds at least PAT_W valid bits

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). rst_n is sampled only on the clk rising edge.
- Reset values: out=0, match_cnt=0, armed=0, shift history=0, fill=0, cfg_pat=0, cfg_ovl=1, state=FILL.
- Sampling: in is used only when in_valid=1. Cycles with in_valid=0 leave history, fill and state unchanged and force out=0.
- History: hist <= {hist[PAT_W-2:0], in}.
- Fill counter: width clog2(PAT_W+1); increments on each valid bit and saturates at PAT_W.
- States:
  - FILL: fill<PAT_W. Go to ARMED when the valid bit makes fill reach PAT_W.
  - ARMED: fill==PAT_W; armed=1. In non-overlap mode a match returns the FSM to FILL.
- Match condition: in_valid && ({hist[PAT_W-2:0], in} == cfg_pat) && (fill+1 >= PAT_W).
- Latency: out is registered and goes high in the cycle after the edge that samples the completing bit. out is a pulse and never stays high without a new match.
- Overlap (cfg_ovl=1): history is kept after a match. With pattern 1010, stream 101010 gives matches on bits 4 and 6.
- Non-overlap (cfg_ovl=0): on a match, fill <= 0 and state <= FILL in the same edge. A new match needs PAT_W fresh bits.
- match_cnt increments by 1 on each match and saturates at 2^CNT_W-1, with no wrap.
- cfg_load=1 (takes priority over in_valid on the same edge):
  - cfg_pat <= pattern, cfg_ovl <= overlap_en.
  - fill, hist and match_cnt are cleared; out <= 0; state <= FILL.
  - The bit presented in that cycle is discarded.
- Reset mid-stream: all state returns to reset values; partial history is lost.
- pattern and overlap_en are ignored except on cfg_load cycles.
- All-zero pattern after reset is legitimate: matches after PAT_W valid zeros.

Optional Feature:
- Macro SEQDET_MASK_EN.
- Defined: adds input port mask[PAT_W-1:0], latched on cfg_load (reset value all-ones). Bit positions with mask=0 are don't-care, and the compare is ((win ^ cfg_pat) & cfg_mask) == 0.
- Undefined: no mask port, exact compare. Behaviour is identical to the defined case with mask all-ones.

Decomposition:
- Package seq_det_pkg holds:
  - state enum {FILL, ARMED};
  - function clog2 for the fill width;
  - localparam limits PAT_W_MIN=2, PAT_W_MAX=16.
- One natural sub-module: sat_counter (parameter W; inc, clr; saturating output). It is used for match_cnt.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles while driving in_valid=1, in=1 -> out=0, match_cnt=0, armed=0 throughout.
2. PAT_W=4, cfg_load with pattern=4'b1010, overlap_en=1, then stream 1,0,1,0,1,0 with in_valid=1 -> out pulses one cycle after bits 4 and 6; match_cnt=2; armed=1 after bit 4.
3. Same pattern, overlap_en=0, stream 1,0,1,0,1,0,1,0 -> out pulses after bits 4 and 8 only; match_cnt=2.
4. in_valid gaps: stream 1,0,(invalid x3),1,0 -> single out pulse one cycle after the final 0; no pulse during gaps.
5. CNT_W=2, pattern 4'b1111, overlap_en=1, 10 ones -> 7 matches; match_cnt saturates at 3; out still pulses on each match.
6. cfg_load asserted mid-pattern after bits 1,0,1 -> match_cnt=0, armed=0; following 0 produces no match; a full new 1010 then matches.
